// File: rtl/shift_mix_engine.sv
// AES encrypt-direction ShiftRows + MixColumns engine with valid/ready handshakes.
// ShiftRows is applied on accept; MixColumns runs COLS_PER_CYCLE columns per clock.
module shift_mix_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("shift_mix_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    state_t       state;
    state_t       state_next;
    logic [1:0]   col;
    logic [2:0]   col_end;
    logic         col_final;
    logic         last;
    logic         armed;
    logic [0:127] work;
    logic [0:127] mixed;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = w;
        return {xtime(a) ^ xtime(b) ^ b ^ c ^ d,
                a ^ xtime(b) ^ xtime(c) ^ c ^ d,
                a ^ b ^ xtime(c) ^ xtime(d) ^ d,
                xtime(a) ^ a ^ b ^ c ^ xtime(d)};
    endfunction

    // Byte (r,c) lives at index 4c+r; row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return res;
    endfunction

    assign accept    = in_valid && in_ready;
    assign col_end   = {1'b0, col} + STEP;
    assign col_final = col_end[2];

    // Column slice for this RUN cycle; the final round passes columns through untouched.
    always_comb begin
        mixed = work;
        for (int c = 0; c < 4; c++) begin
            if (!last && c >= int'(col) && c < int'(col) + COLS_PER_CYCLE) begin
                mixed[32*c +: 32] = mix_column(work[32*c +: 32]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (col_final) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // armed keeps in_ready low until the first edge after reset releases.
    always_comb begin
        in_ready  = (state == IDLE) && armed;
        out_valid = (state == DONE);
        out_state = work;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
            col   <= 2'd0;
            last  <= 1'b0;
            work  <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        work <= shift_rows(in_state);
                        last <= in_last;
                        col  <= 2'd0;
                    end
                end
                RUN: begin
                    work <= mixed;
                    col  <= col_end[1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mix_engine.sv
// Directed bench running three engine instances (1, 2, 4 columns per cycle) in lockstep.
module tb_shift_mix_engine;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic [0:127] in_state;
    logic         in_last;
    logic         out_ready;
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic [0:127] out_state_a [3];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{4, 2, 1};

    typedef struct {
        logic [0:127] s;
        logic         l;
        logic [0:127] e;
    } vec_t;

    vec_t vecs [5];

    shift_mix_engine #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[0]),
        .in_state(in_state), .in_last(in_last), .out_valid(out_valid_a[0]),
        .out_ready(out_ready), .out_state(out_state_a[0]));

    shift_mix_engine #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[1]),
        .in_state(in_state), .in_last(in_last), .out_valid(out_valid_a[1]),
        .out_ready(out_ready), .out_state(out_state_a[1]));

    shift_mix_engine #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a[2]),
        .in_state(in_state), .in_last(in_last), .out_valid(out_valid_a[2]),
        .out_ready(out_ready), .out_state(out_state_a[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_ready(input string tag, input logic exp);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s in_ready[%0d]", tag, i), 128'(in_ready_a[i]), 128'(exp));
    endtask

    // Accept one block on all instances, check valid timing, result, and release.
    task automatic run_block(input string tag, input vec_t v);
        chk_all_ready({tag, " pre"}, 1'b1);
        in_state  = v.s;
        in_last   = v.l;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_state = 128'hdeadbeef_0badf00d_cafebabe_12345678;
        in_last  = ~v.l;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s valid@0[%0d]", tag, i), 128'(out_valid_a[i]), 128'(0));
        chk_all_ready({tag, " busy"}, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s valid@%0d[%0d]", tag, k, i), 128'(out_valid_a[i]),
                    128'(k >= lat[i]));
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s state[%0d]", tag, i), out_state_a[i], v.e);
        chk_all_ready({tag, " done"}, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s valid_rel[%0d]", tag, i), 128'(out_valid_a[i]), 128'(0));
        chk_all_ready({tag, " idle"}, 1'b1);
    endtask

    initial begin
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                    128'h00050a0f04090e03080d02070c01060b};
        vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                    128'h046681e5e0cb199a48f8d37a2806264c};
        vecs[2] = '{128'hdb000000001300000000530000000045, 1'b0,
                    128'h8e4da1bc000000000000000000000000};
        vecs[3] = '{128'hdb26d45cf21331d5d40a534c2dd42245, 1'b0,
                    128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8};
        vecs[4] = '{128'hdb26d45cf21331d5d40a534c2dd42245, 1'b1,
                    128'hdb135345f20a225cd4d4d4d52d26314c};

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst valid[%0d]", i), 128'(out_valid_a[i]), 128'(0));
            chk($sformatf("rst state[%0d]", i), out_state_a[i], 128'h0);
        end
        chk_all_ready("rst", 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk_all_ready("post-rst pre-edge", 1'b0);
        tick();
        chk_all_ready("post-rst edge1", 1'b1);

        for (int n = 0; n < 5; n++)
            run_block($sformatf("vec%0d", n), vecs[n]);

        // Downstream stall: DONE holds while out_ready stays low; new offers are ignored.
        in_state  = vecs[1].s;
        in_last   = vecs[1].l;
        in_valid  = 1'b1;
        tick();
        in_state = vecs[0].s;
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("stall%0d valid[%0d]", k, i), 128'(out_valid_a[i]), 128'(1));
                chk($sformatf("stall%0d state[%0d]", k, i), out_state_a[i], vecs[1].e);
            end
            chk_all_ready($sformatf("stall%0d", k), 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("stall rel valid[%0d]", i), 128'(out_valid_a[i]), 128'(0));
        chk_all_ready("stall rel", 1'b1);

        // Abort mid-block with an asynchronous reset pulse, then reprocess cleanly.
        in_state = vecs[1].s;
        in_last  = vecs[1].l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort valid[%0d]", i), 128'(out_valid_a[i]), 128'(0));
            chk($sformatf("abort state[%0d]", i), out_state_a[i], 128'h0);
        end
        chk_all_ready("abort", 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_all_ready("abort recover", 1'b1);
        run_block("post-abort", vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
